// File: rtl/vga_rx_pkg.sv
// vga_rx_pkg: receiver state encoding and default 640x480@60 timing shared with the generator
package vga_rx_pkg;
  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} rx_state_t;
  localparam int H_ACTIVE = 640;
  localparam int H_SYNC = 96;
  localparam int H_BP = 48;
  localparam int H_TOTAL = 800;
  localparam int V_ACTIVE = 480;
  localparam int V_SYNC = 2;
  localparam int V_BP = 33;
  localparam int V_TOTAL = 525;
  localparam int LOCK_FRAMES = 2;
  localparam logic [9:0] CNT_MAX = 10'h3ff;
endpackage

// File: rtl/vga_rx_edge.sv
// vga_rx_edge: samples d on ce (sample resets to 1) and flags fall/rise against the previous sample
module vga_rx_edge (
  input  logic Clk,
  input  logic Reset_n,
  input  logic ce,
  input  logic d,
  output logic fall,
  output logic rise
);
  logic s_q, s_d;
  always_comb s_d = ce ? d : s_q;
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) s_q <= 1'b1;
    else s_q <= s_d;
  assign fall = ce & s_q & ~d;
  assign rise = ce & ~s_q & d;
endmodule

// File: rtl/vga_sync_receiver.sv
// vga_sync_receiver: rebuilds RxX/RxY from hs/vs edges, checks timing, locks after clean frames; in: Clk Reset_n pix_ce hs vs blank clr_err, out: RxX RxY rx_active locked frame_start err_* lock_loss_cnt
module vga_sync_receiver
  import vga_rx_pkg::*;
#(
  parameter int HA = H_ACTIVE,
  parameter int HS = H_SYNC,
  parameter int HB = H_BP,
  parameter int HT = H_TOTAL,
  parameter int VA = V_ACTIVE,
  parameter int VS = V_SYNC,
  parameter int VB = V_BP,
  parameter int VT = V_TOTAL,
  parameter int LF = LOCK_FRAMES
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       pix_ce,
  input  logic       hs,
  input  logic       vs,
  input  logic       blank,
  input  logic       clr_err,
  output logic [9:0] RxX,
  output logic [9:0] RxY,
  output logic       rx_active,
  output logic       locked,
  output logic       frame_start,
  output logic       err_h,
  output logic       err_v,
  output logic       err_blank,
  output logic [7:0] lock_loss_cnt
);
  localparam logic [9:0] H_LAST = 10'(HT - 1);
  localparam logic [9:0] H_SW = 10'(HS);
  localparam logic [9:0] H_OFF = 10'(HS + HB);
  localparam logic [9:0] H_END = 10'(HS + HB + HA - 1);
  localparam logic [9:0] V_LAST = 10'(VT - 1);
  localparam logic [9:0] V_SW = 10'(VS);
  localparam logic [9:0] V_OFF = 10'(VS + VB);
  localparam logic [9:0] V_END = 10'(VS + VB + VA - 1);
  localparam logic [3:0] GOOD_N = 4'(LF);
  logic hs_fall, hs_rise, vs_start, vs_end;
  logic h_fail, v_fail, fail, tracking;
  rx_state_t state_q, state_d;
  logic [3:0] good_q, good_d;
  logic [9:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d, rx_x_q, rx_x_d, rx_y_q, rx_y_d;
  logic rx_active_q, rx_active_d, locked_q, locked_d, frame_start_q, frame_start_d;
  logic err_h_q, err_h_d, err_v_q, err_v_d, err_blank_q, err_blank_d;
  logic [7:0] lock_loss_q, lock_loss_d;
  vga_rx_edge u_hs (.Clk(Clk), .Reset_n(Reset_n), .ce(pix_ce), .d(hs), .fall(hs_fall), .rise(hs_rise));
  // vs is only looked at on hs_fall, so its sample register is the per-line vs_l
  vga_rx_edge u_vs (.Clk(Clk), .Reset_n(Reset_n), .ce(hs_fall), .d(vs), .fall(vs_start), .rise(vs_end));
  always_comb begin
    h_cnt_d = hs_fall ? '0 : (pix_ce && h_cnt_q != CNT_MAX) ? h_cnt_q + 10'd1 : h_cnt_q;
    v_cnt_d = vs_start ? '0 : (hs_fall && v_cnt_q != CNT_MAX) ? v_cnt_q + 10'd1 : v_cnt_q;
    // sync-width checks use the post-update count so the first high sample counts as the width
    h_fail = (hs_fall && h_cnt_q != H_LAST) || (hs_rise && h_cnt_d != H_SW) ||
             (pix_ce && !hs_fall && h_cnt_q == CNT_MAX);
    v_fail = (vs_start && v_cnt_q != V_LAST) || (vs_end && v_cnt_d != V_SW) ||
             (hs_fall && !vs_start && v_cnt_q == CNT_MAX);
    tracking = state_q != SEARCH;
    fail = tracking && (h_fail || v_fail);
    rx_active_d = h_cnt_d >= H_OFF && h_cnt_d <= H_END && v_cnt_d >= V_OFF && v_cnt_d <= V_END;
    rx_x_d = rx_active_d ? h_cnt_d - H_OFF : '0;
    rx_y_d = rx_active_d ? v_cnt_d - V_OFF : '0;
    state_d = state_q;
    good_d = good_q;
    if (state_q == SEARCH) begin
      state_d = vs_start ? TRACK : SEARCH;
      good_d = vs_start ? '0 : good_q;
    end else if (fail) begin
      state_d = SEARCH;
    end else if (vs_start && state_q == TRACK) begin
      good_d = good_q + 4'd1;
      state_d = (good_d == GOOD_N) ? LOCKED : TRACK;
    end
    locked_d = state_d == LOCKED;
    frame_start_d = vs_start;
    err_h_d = (err_h_q && !clr_err) || (tracking && h_fail);
    err_v_d = (err_v_q && !clr_err) || (tracking && v_fail);
    err_blank_d = (err_blank_q && !clr_err) || (state_q == LOCKED && pix_ce && blank != rx_active_d);
    lock_loss_d = (state_q == LOCKED && fail && lock_loss_q != 8'hff) ? lock_loss_q + 8'd1 : lock_loss_q;
  end
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      state_q <= SEARCH;
      good_q <= '0;
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      rx_x_q <= '0;
      rx_y_q <= '0;
      rx_active_q <= 1'b0;
      locked_q <= 1'b0;
      frame_start_q <= 1'b0;
      err_h_q <= 1'b0;
      err_v_q <= 1'b0;
      err_blank_q <= 1'b0;
      lock_loss_q <= '0;
    end else begin
      state_q <= state_d;
      good_q <= good_d;
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      rx_x_q <= rx_x_d;
      rx_y_q <= rx_y_d;
      rx_active_q <= rx_active_d;
      locked_q <= locked_d;
      frame_start_q <= frame_start_d;
      err_h_q <= err_h_d;
      err_v_q <= err_v_d;
      err_blank_q <= err_blank_d;
      lock_loss_q <= lock_loss_d;
    end
  assign RxX = rx_x_q;
  assign RxY = rx_y_q;
  assign rx_active = rx_active_q;
  assign locked = locked_q;
  assign frame_start = frame_start_q;
  assign err_h = err_h_q;
  assign err_v = err_v_q;
  assign err_blank = err_blank_q;
  assign lock_loss_cnt = lock_loss_q;
endmodule

// File: tb/tb_vga_sync_receiver.sv
// tb_vga_sync_receiver: directed frames on a reduced 16x12 timing with pix_ce every 2nd Clk
module tb_vga_sync_receiver;
  localparam int HA = 8, HS = 4, HB = 2, HT = 16, VA = 4, VS = 2, VB = 3, VT = 12;
  logic Clk = 0, Reset_n = 0, pix_ce = 0, hs = 1, vs = 1, blank = 0, clr_err = 0;
  logic [9:0] RxX, RxY;
  logic rx_active, locked, frame_start, err_h, err_v, err_blank;
  logic [7:0] lock_loss_cnt;
  int checks = 0, errors = 0, fs_cnt = 0, fs_long = 0;
  logic [9:0] snap_x, snap_y, probe_x, probe_y;
  logic snap_act, snap_lock, probe_act, lock_first;
  vga_sync_receiver #(.HA(HA), .HS(HS), .HB(HB), .HT(HT), .VA(VA), .VS(VS), .VB(VB), .VT(VT), .LF(2)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .pix_ce(pix_ce), .hs(hs), .vs(vs), .blank(blank), .clr_err(clr_err),
    .RxX(RxX), .RxY(RxY), .rx_active(rx_active), .locked(locked), .frame_start(frame_start),
    .err_h(err_h), .err_v(err_v), .err_blank(err_blank), .lock_loss_cnt(lock_loss_cnt));
  always #5 Clk = ~Clk;
  task automatic gen_pix(input int ln, input int px, input int vsw, input bit b0);
    hs = px >= HS;
    vs = ln >= vsw;
    blank = !b0 && px >= HS + HB && px < HS + HB + HA && ln >= VS + VB && ln < VS + VB + VA;
    pix_ce = 1;
    @(posedge Clk); #1;
    pix_ce = 0;
    snap_x = RxX; snap_y = RxY; snap_act = rx_active; snap_lock = locked;
    if (frame_start) fs_cnt++;
    @(posedge Clk); #1;
    if (frame_start) fs_long++;
  endtask
  task automatic run_frame(input int vsw, input int bad_ln, input int bad_len, input int b_ln, input int b_px,
                           input int p_ln, input int p_px, input int nlines);
    for (int ln = 0; ln < nlines; ln++)
      for (int px = 0; px < ((ln == bad_ln) ? bad_len : HT); px++) begin
        gen_pix(ln, px, vsw, ln == b_ln && px == b_px);
        if (ln == 0 && px == 0) lock_first = snap_lock;
        if (ln == p_ln && px == p_px) begin probe_x = snap_x; probe_y = snap_y; probe_act = snap_act; end
      end
  endtask
  task automatic clean_frame(input int p_ln, input int p_px);
    run_frame(VS, -1, 0, -1, -1, p_ln, p_px, VT);
  endtask
  task automatic clr_pulse();
    clr_err = 1;
    @(posedge Clk); #1;
    clr_err = 0;
  endtask
  task automatic test_reset();
    repeat (3) @(posedge Clk);
    #1;
    checks++; if ({rx_active, locked, frame_start, err_h, err_v, err_blank} !== 6'b0) begin errors++; $display("FAIL reset_flags got=%b exp=000000", {rx_active, locked, frame_start, err_h, err_v, err_blank}); end
    checks++; if ({RxX, RxY} !== 20'd0) begin errors++; $display("FAIL reset_pos got=%0d,%0d exp=0,0", RxX, RxY); end
    checks++; if (lock_loss_cnt !== 8'd0) begin errors++; $display("FAIL reset_lossc got=%0d exp=0", lock_loss_cnt); end
    Reset_n = 1;
    @(posedge Clk); #1;
  endtask
  task automatic test_lock();
    clean_frame(5, 5);
    checks++; if (probe_act !== 1'b0 || probe_x !== 10'd0) begin errors++; $display("FAIL lock_pre_window got act=%b x=%0d exp act=0 x=0", probe_act, probe_x); end
    clean_frame(5, 6);
    checks++; if ({probe_act, probe_x, probe_y} !== {1'b1, 10'd0, 10'd0}) begin errors++; $display("FAIL lock_origin got act=%b x=%0d y=%0d exp 1,0,0", probe_act, probe_x, probe_y); end
    checks++; if (lock_first !== 1'b0 || locked !== 1'b0) begin errors++; $display("FAIL lock_early got=%b/%b exp=0/0", lock_first, locked); end
    clean_frame(8, 13);
    checks++; if (lock_first !== 1'b1) begin errors++; $display("FAIL lock_rise got=%b exp=1", lock_first); end
    checks++; if ({probe_act, probe_x, probe_y} !== {1'b1, 10'd7, 10'd3}) begin errors++; $display("FAIL lock_corner got act=%b x=%0d y=%0d exp 1,7,3", probe_act, probe_x, probe_y); end
    checks++; if (fs_cnt !== 3 || fs_long !== 0) begin errors++; $display("FAIL frame_start got pulses=%0d long=%0d exp 3,0", fs_cnt, fs_long); end
    checks++; if ({err_h, err_v, err_blank} !== 3'b0) begin errors++; $display("FAIL lock_errs got=%b exp=000", {err_h, err_v, err_blank}); end
  endtask
  task automatic test_line_len();
    run_frame(VS, 5, HT + 1, -1, -1, -1, -1, VT);
    checks++; if ({err_h, err_v, locked} !== 3'b100) begin errors++; $display("FAIL linelen_flags got h,v,lock=%b exp=100", {err_h, err_v, locked}); end
    checks++; if (lock_loss_cnt !== 8'd1) begin errors++; $display("FAIL linelen_lossc got=%0d exp=1", lock_loss_cnt); end
    clean_frame(-1, -1);
    clean_frame(-1, -1);
    checks++; if (lock_first !== 1'b0) begin errors++; $display("FAIL relock_early got=%b exp=0", lock_first); end
    clean_frame(-1, -1);
    checks++; if (lock_first !== 1'b1) begin errors++; $display("FAIL relock got=%b exp=1", lock_first); end
  endtask
  task automatic test_blank();
    run_frame(VS, -1, 0, 7, 9, 7, 9, VT);
    checks++; if ({probe_act, probe_x, probe_y} !== {1'b1, 10'd3, 10'd2}) begin errors++; $display("FAIL blank_pos got act=%b x=%0d y=%0d exp 1,3,2", probe_act, probe_x, probe_y); end
    checks++; if ({err_blank, locked} !== 2'b11) begin errors++; $display("FAIL blank_err got blank,lock=%b exp=11", {err_blank, locked}); end
    clr_pulse();
    checks++; if ({err_blank, err_h} !== 2'b00) begin errors++; $display("FAIL clr_err got blank,h=%b exp=00", {err_blank, err_h}); end
    checks++; if (lock_loss_cnt !== 8'd1) begin errors++; $display("FAIL clr_keeps_lossc got=%0d exp=1", lock_loss_cnt); end
  endtask
  task automatic test_h_sat();
    for (int i = 0; i < 1000; i++) gen_pix(VT - 1, HT - 1, VS, 0);
    checks++; if (locked !== 1'b1 || err_h !== 1'b0) begin errors++; $display("FAIL hsat_early got lock,h=%b%b exp=10", locked, err_h); end
    for (int i = 0; i < 100; i++) gen_pix(VT - 1, HT - 1, VS, 0);
    checks++; if ({locked, err_h, err_v, rx_active} !== 4'b0100) begin errors++; $display("FAIL hsat got lock,h,v,act=%b exp=0100", {locked, err_h, err_v, rx_active}); end
    checks++; if (lock_loss_cnt !== 8'd2) begin errors++; $display("FAIL hsat_lossc got=%0d exp=2", lock_loss_cnt); end
  endtask
  task automatic test_vsync_width();
    clr_pulse();
    run_frame(VS + 1, -1, 0, -1, -1, -1, -1, VT);
    checks++; if ({err_v, err_h, locked} !== 3'b100) begin errors++; $display("FAIL vsw got v,h,lock=%b exp=100", {err_v, err_h, locked}); end
    checks++; if (lock_loss_cnt !== 8'd2) begin errors++; $display("FAIL vsw_lossc got=%0d exp=2", lock_loss_cnt); end
  endtask
  task automatic test_reset_mid();
    clean_frame(-1, -1);
    clean_frame(-1, -1);
    clean_frame(-1, -1);
    checks++; if (lock_first !== 1'b1) begin errors++; $display("FAIL recover_lock got=%b exp=1", lock_first); end
    run_frame(VS, -1, 0, -1, -1, -1, -1, 6);
    for (int px = 0; px < 10; px++) gen_pix(6, px, VS, 0);
    checks++; if ({locked, rx_active, RxX, RxY} !== {2'b11, 10'd3, 10'd1}) begin errors++; $display("FAIL mid_pos got lock=%b act=%b x=%0d y=%0d exp 1,1,3,1", locked, rx_active, RxX, RxY); end
    Reset_n = 0;
    #1;
    checks++; if ({locked, rx_active, frame_start, err_h, err_v, err_blank} !== 6'b0) begin errors++; $display("FAIL rst_async_flags got=%b exp=000000", {locked, rx_active, frame_start, err_h, err_v, err_blank}); end
    checks++; if ({RxX, RxY} !== 20'd0 || lock_loss_cnt !== 8'd0) begin errors++; $display("FAIL rst_async_vals got x=%0d y=%0d lc=%0d exp 0,0,0", RxX, RxY, lock_loss_cnt); end
    repeat (2) @(posedge Clk);
    #1;
    Reset_n = 1;
    clean_frame(-1, -1);
    clean_frame(-1, -1);
    checks++; if (lock_first !== 1'b0) begin errors++; $display("FAIL rst_first_counted got=%b exp=0", lock_first); end
    clean_frame(-1, -1);
    checks++; if (lock_first !== 1'b1) begin errors++; $display("FAIL rst_relock got=%b exp=1", lock_first); end
  endtask
  initial begin
    test_reset();
    test_lock();
    test_line_len();
    test_blank();
    test_h_sat();
    test_vsync_width();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
